array_reduce: RTL

ARRAY_REDUCE -- requirements
Module: array_reduce

---
 rtl/array_reduce_pkg.sv | 37 +++
 rtl/array_reduce_rd_pipe.sv | 49 ++++
 rtl/array_reduce.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/array_reduce_pkg.sv
// array_reduce_pkg: reduce-mode and FSM-state enums plus the identity helper
// shared by array_reduce and its read pipeline.
package array_reduce_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        MODE_SUM = 2'd0,
        MODE_MIN = 2'd1,
        MODE_MAX = 2'd2,
        MODE_XOR = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Neutral start value of each reduction, valid in the low w bits.
    function automatic logic [MAX_W-1:0] mode_identity(
        input mode_e       m,
        input int unsigned w
    );
        logic [MAX_W-1:0] msb;
        logic [MAX_W-1:0] id;
        msb = 64'd1 << (w - 1);
        unique case (m)
            MODE_MIN: id = msb - 64'd1;
            MODE_MAX: id = msb;
            default:  id = '0;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/array_reduce_rd_pipe.sv
// arr_rd_pipe: RD_LAT-deep valid/index shift register that tags each
// memory return with the element index it belongs to.
module arr_rd_pipe
    import array_reduce_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_idx,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_idx
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] vld_d;
    logic [ADDR_W-1:0] idx_q [RD_LAT];
    logic [ADDR_W-1:0] idx_d [RD_LAT];

    always_comb begin
        vld_d    = '0;
        vld_d[0] = in_valid;
        idx_d[0] = in_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/array_reduce.sv
// array_reduce: streams n elements from a latency-RD_LAT memory and folds
// them by sum/min/max/xor. ARRAY_REDUCE_PREFIX_EN adds in-place prefix writes.
module array_reduce
    import array_reduce_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              finish,
    input  logic [ADDR_W-1:0] n,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] res,
    output logic              arr_clk,
    output logic              arr_read_en,
    output logic [ADDR_W-1:0] arr_read_addr_arg,
    input  logic [DATA_W-1:0] arr_read_val_ret,
    output logic              arr_write_en,
    output logic [ADDR_W-1:0] arr_write_addr_arg,
    output logic [DATA_W-1:0] arr_write_val_arg
);

    state_e            state_q;
    state_e            state_d;
    mode_e             mode_q;
    mode_e             mode_d;
    logic [ADDR_W-1:0] n_q;
    logic [ADDR_W-1:0] n_d;
    logic              rd_en_q;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] res_d;
    logic              finish_q;
    logic              finish_d;

    logic              ret_vld;
    logic [ADDR_W-1:0] ret_idx;
    logic [ADDR_W-1:0] last_idx;
    logic [DATA_W-1:0] acc;
    logic              last_ret;
    logic              drain_done;

    arr_rd_pipe #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_en_q),
        .in_idx    (rd_addr_q),
        .out_valid (ret_vld),
        .out_idx   (ret_idx)
    );

    function automatic logic [DATA_W-1:0] combine(
        input mode_e             m,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] x
    );
        logic [DATA_W-1:0] r;
        unique case (m)
            MODE_SUM: r = a + x;
            MODE_MIN: r = ($signed(x) < $signed(a)) ? x : a;
            MODE_MAX: r = ($signed(x) > $signed(a)) ? x : a;
            default:  r = a ^ x;
        endcase
        return r;
    endfunction

    assign last_idx = n_q - ADDR_W'(1);
    assign acc      = combine(mode_q, res_q, arr_read_val_ret);
    assign last_ret = ret_vld && (ret_idx == last_idx);

`ifdef ARRAY_REDUCE_PREFIX_EN
    logic              wr_en_q;
    logic              wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_val_q;
    logic [DATA_W-1:0] wr_val_d;

    // Write-back trails accumulation by one cycle and carries the new res.
    always_comb begin
        wr_en_d   = ret_vld;
        wr_addr_d = ret_vld ? ret_idx : '0;
        wr_val_d  = ret_vld ? acc : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_val_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_val_q  <= wr_val_d;
        end
    end

    assign drain_done         = wr_en_q && (wr_addr_q == last_idx);
    assign arr_write_en       = wr_en_q;
    assign arr_write_addr_arg = wr_addr_q;
    assign arr_write_val_arg  = wr_val_q;
`else
    assign drain_done         = last_ret;
    assign arr_write_en       = 1'b0;
    assign arr_write_addr_arg = '0;
    assign arr_write_val_arg  = '0;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        n_d       = n_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        res_d     = res_q;
        finish_d  = 1'b0;
        if (ret_vld) begin
            res_d = acc;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d    = n;
                    mode_d = mode_e'(mode);
                    res_d  = DATA_W'(mode_identity(mode_e'(mode), DATA_W));
                    if (n == '0) begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d   = ST_READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end
                end
            end
            ST_READ: begin
                if (rd_addr_q == last_idx) begin
                    state_d   = ST_DRAIN;
                    rd_en_d   = 1'b0;
                    rd_addr_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d  = ST_DONE;
                    finish_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_SUM;
            n_q       <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            res_q     <= '0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            n_q       <= n_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            res_q     <= res_d;
            finish_q  <= finish_d;
        end
    end

    assign arr_clk           = clk;
    assign arr_read_en       = rd_en_q;
    assign arr_read_addr_arg = rd_addr_q;
    assign res               = res_q;
    assign finish            = finish_q;

endmodule
